sig_stream_decode: RTL and testbench
====================================

# sig_stream_decode

Streaming, parameter-set-generic ML-DSA signature decoder (FIPS 204 sigDecode) for the verify path. It consumes the encoded signature as a valid/ready byte stream rather than a flat vector, and captures c_tilde. It emits z coefficients one at a time with backpressure, and rebuilds the hint bitmap with full malformed-hint and length checking. A single instance covers ML-DSA-44/65/87 by parameter.

## Interface
- LAMBDA, 192, collision strength; c_tilde length CT = LAMBDA/4 bytes
- L, 5, number of z polynomials
- K, 6, number of hint polynomials
- OMEGA, 55, maximum hint weight
- GAMMA1_BITS, 19, log2(gamma1); packed z coefficient width B = GAMMA1_BITS+1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a decode from IDLE or DONE
- in_data  in  8  signature byte, transmission order
- in_valid / in_ready  in / out  1  byte handshake
- in_last  in  1  marks the final signature byte
- c_tilde  out  8*CT  byte j in bits [8j+7:8j]; held until next start
- z_coeff  out  32  signed two's-complement coefficient = gamma1 - field
- z_poly / z_idx  out  clog2(L) / 8  polynomial and coefficient index of z_coeff
- z_valid / z_ready  out / in  1  coefficient handshake
- h  out  K*256  hint bitmap, bit 256*i+j = h[i][j]
- done  out  1  one-cycle pulse at end of decode
- sig_ok  out  1  valid from done until next start; 1 = well-formed
- err_len / err_hint  out  1  sticky cause flags, cleared on start

## Operation
- States: IDLE, CT, Z, HBUF, HCHK, DONE. start in IDLE/DONE → CT; clears h, the flags, and the counters. start in any other state is ignored.
- CT: in_ready=1; byte j is written to c_tilde byte j. After CT bytes → Z.
- Z: bit accumulator (≥ B+7 bits), LSB-first packing. Each byte is appended above the current acc_bits.
- Z, field emit: z_valid = (acc_bits ≥ B), and z_coeff = (1<<GAMMA1_BITS) - acc[B-1:0], sign-extended. On z_valid&&z_ready, shift out B bits and advance z_idx (wraps 255→0, then z_poly++).
- Z, byte intake: in_ready = (acc_bits < B). Intake and emit are therefore never concurrent.
- Z exit: after L*256 coefficients with acc_bits = 0 → HBUF.
- HBUF: in_ready=1; OMEGA+K bytes are stored in y[0..OMEGA+K-1]. After the last one → HCHK.
- HCHK inspects one entry per cycle. Index=0; for i in 0..K-1, with cnt = y[OMEGA+i]:
  - cnt < Index or cnt > OMEGA → err_hint.
  - For each Index < cnt: if Index > first_i and y[Index-1] ≥ y[Index] → err_hint. Otherwise set h[i][y[Index]], then Index++.
  - Trailing check: any y[Index..OMEGA-1] ≠ 0 → err_hint.
  - On the first err_hint, go to DONE immediately.
- Length rules:
  - in_last on any byte other than byte CT+L*32*B+OMEGA+K-1 → err_len, go to DONE at once.
  - Final byte without in_last → err_len; decoding completes.
- DONE: done pulses on entry; sig_ok = !err_len && !err_hint. in_ready=0, z_valid=0.
- Reset values: in_ready 0, z_valid 0, done 0, sig_ok 0, err_* 0, c_tilde 0, h 0, z_poly/z_idx 0, state IDLE.
- Reset mid-operation returns to IDLE and abandons any partially accepted coefficient.

## Timing
- Byte accepted on in_valid&&in_ready at the rising edge. Coefficient accepted on z_valid&&z_ready.
- z_valid/z_coeff are combinational from the accumulator. They stay stable while z_ready=0.
- Z throughput: at most 1 byte or 1 coefficient per cycle. Minimum 32*B + 256 cycles per polynomial with z_ready=1.
- HCHK latency: ≤ 2*OMEGA + K cycles; done 1 cycle after HCHK ends.
- c_tilde is final 1 cycle after its last byte. Each h bit is final when set.

## Test plan
- ML-DSA-65, CT=48 bytes 0x00..0x2F, z bytes all 0x00, hint bytes all 0x00, in_last on byte 3308 → c_tilde byte j = j; 1280 coefficients all 524288; h=0; done with sig_ok=1.
- First z bytes 0xFF,0xFF,0x0F (field 2^20-1) → z_coeff = 524288 - 1048575 = -524287 at z_poly=0, z_idx=0.
- Hint: y[0..2] = 3,7,200; counts y[55..60] = 3,3,3,3,3,3 → h[0][3], h[0][7], h[0][200] set; sig_ok=1. Then y[0..1] = 7,3 → err_hint, sig_ok=0.
- Hint count y[55] = 56 (> OMEGA) → err_hint, done within 2 cycles of HCHK entry. Nonzero y[10] with total weight 3 → err_hint.
- in_last on byte 100 → err_len, done; in_ready=0 afterwards. Missing in_last on byte 3308 → sig_ok=0 with h still decoded.
- Random z_ready toggling (30% duty) → coefficient sequence identical to the z_ready=1 run. rst asserted mid-Z → IDLE, all outputs at reset values; a subsequent start decodes correctly.

Source files
------------

// File: rtl/sig_stream_decode.sv
// sig_stream_decode
//   Streaming ML-DSA signature decoder (sigDecode) for the verify path.
//   The signature arrives as a valid/ready byte stream in transmission order:
//   c_tilde, then L packed z polynomials, then the OMEGA+K byte hint block.
//   c_tilde is captured, z coefficients are emitted one per handshake, and the
//   hint block is buffered and then checked one entry per cycle while the hint
//   bitmap is rebuilt.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   start                    pulse; begins a decode from IDLE or DONE
//   in_data/in_valid/in_ready/in_last   signature byte stream
//   c_tilde                  captured commitment hash, byte j at [8j+7:8j]
//   z_coeff/z_poly/z_idx     signed z coefficient and its position
//   z_valid/z_ready          coefficient handshake
//   h                        hint bitmap, bit 256*i+j = h[i][j]
//   done                     one-cycle pulse on entering DONE
//   sig_ok                   well-formed flag, valid while in DONE
//   err_len/err_hint         sticky error causes, cleared on start
module sig_stream_decode #(
    parameter int LAMBDA      = 192,
    parameter int L           = 5,
    parameter int K           = 6,
    parameter int OMEGA       = 55,
    parameter int GAMMA1_BITS = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    output logic [8*(LAMBDA/4)-1:0]    c_tilde,
    output logic signed [31:0]         z_coeff,
    output logic [$clog2(L)-1:0]       z_poly,
    output logic [7:0]                 z_idx,
    output logic                       z_valid,
    input  logic                       z_ready,
    output logic [K*256-1:0]           h,
    output logic                       done,
    output logic                       sig_ok,
    output logic                       err_len,
    output logic                       err_hint
);

    localparam int DATA_W = 8;
    localparam int COEF_W = 32;
    localparam int CT     = LAMBDA / 4;
    localparam int B      = GAMMA1_BITS + 1;
    localparam int ZBYTES = L * 32 * B;
    localparam int HB     = OMEGA + K;
    localparam int TOTAL  = CT + ZBYTES + HB;
    localparam int ACC_W  = B + DATA_W;
    localparam int ABW    = $clog2(ACC_W);
    localparam int BCW    = $clog2(TOTAL);
    localparam int PW     = $clog2(L);
    localparam int HIW    = $clog2(K);
    localparam int YAW    = $clog2(HB);
    localparam int SCW    = $clog2((HB > CT) ? HB : CT);

    localparam logic [ABW-1:0] B_A = ABW'(B);

    typedef enum logic [2:0] {S_IDLE, S_CT, S_Z, S_HBUF, S_HCHK, S_DONE} state_t;
    typedef enum logic [1:0] {P_CNT, P_ENT, P_TRL} phase_t;

    state_t state, state_nxt;
    phase_t phase, phase_nxt;

    // Control
    logic [BCW-1:0] byte_cnt;
    logic [SCW-1:0] sec_cnt;
    logic [ABW-1:0] acc_bits;
    logic [HIW-1:0] hi;
    logic [YAW-1:0] hidx;
    logic [YAW-1:0] first_i;

    // Data (no reset)
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] y [0:HB-1];

    logic accept, z_fire, z_last, last_pos, start_ok;
    logic len_set, hint_set, hint_fin, poly_adv;
    logic hi_inc, hidx_inc, first_ld, h_wr;
    logic [YAW-1:0]    cnt_addr, prev_addr;
    logic [DATA_W-1:0] hcnt, hent, hprev;
    logic [7:0]        hidx8, first8;

    // Packed field f encodes gamma1 - z, so z = gamma1 - f.
    function automatic logic signed [COEF_W-1:0] to_coeff(input logic [B-1:0] f);
        logic signed [COEF_W-1:0] g;
        g = $signed(COEF_W'(1) << GAMMA1_BITS);
        return g - $signed(COEF_W'(f));
    endfunction

    assign in_ready = (state == S_CT) || (state == S_HBUF) ||
                      ((state == S_Z) && (acc_bits < B_A));
    assign z_valid  = (state == S_Z) && (acc_bits >= B_A);
    assign z_coeff  = to_coeff(acc[B-1:0]);
    assign accept   = in_valid && in_ready;
    assign z_fire   = z_valid && z_ready;
    assign z_last   = (z_poly == PW'(L - 1)) && (z_idx == 8'd255);
    assign last_pos = (byte_cnt == BCW'(TOTAL - 1));
    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign sig_ok   = (state == S_DONE) && !err_len && !err_hint;

    assign cnt_addr  = YAW'(OMEGA) + YAW'(hi);
    assign prev_addr = (hidx == '0) ? '0 : hidx - 1'b1;
    assign hcnt      = y[cnt_addr];
    assign hent      = y[hidx];
    assign hprev     = y[prev_addr];
    assign hidx8     = 8'(hidx);
    assign first8    = 8'(first_i);

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        len_set   = 1'b0;
        hint_set  = 1'b0;
        hint_fin  = 1'b0;
        poly_adv  = 1'b0;
        hi_inc    = 1'b0;
        hidx_inc  = 1'b0;
        first_ld  = 1'b0;
        h_wr      = 1'b0;

        case (state)
            S_IDLE: if (start) state_nxt = S_CT;
            S_CT:   if (accept && sec_cnt == SCW'(CT - 1)) state_nxt = S_Z;
            S_Z:    if (z_fire && z_last && acc_bits == B_A) state_nxt = S_HBUF;
            S_HBUF: if (accept && sec_cnt == SCW'(HB - 1)) state_nxt = S_HCHK;
            S_HCHK: begin
                case (phase)
                    // Read the cumulative count for polynomial hi.
                    P_CNT: begin
                        if (hcnt < hidx8 || hcnt > 8'(OMEGA)) begin
                            hint_set = 1'b1;
                        end else begin
                            first_ld = 1'b1;
                            if (hcnt == hidx8) poly_adv = 1'b1;
                            else               phase_nxt = P_ENT;
                        end
                    end
                    // Positions within one polynomial must be strictly increasing.
                    P_ENT: begin
                        if (hidx8 > first8 && hprev >= hent) begin
                            hint_set = 1'b1;
                        end else begin
                            h_wr     = 1'b1;
                            hidx_inc = 1'b1;
                            if (hidx8 + 8'd1 == hcnt) poly_adv = 1'b1;
                        end
                    end
                    // Unused index slots must be zero padding.
                    default: begin
                        if (hidx == YAW'(OMEGA))  hint_fin = 1'b1;
                        else if (hent != '0)      hint_set = 1'b1;
                        else                      hidx_inc = 1'b1;
                    end
                endcase
                if (poly_adv) begin
                    if (hi == HIW'(K - 1)) begin
                        phase_nxt = P_TRL;
                    end else begin
                        hi_inc    = 1'b1;
                        phase_nxt = P_CNT;
                    end
                end
                if (hint_set || hint_fin) state_nxt = S_DONE;
            end
            S_DONE:  if (start) state_nxt = S_CT;
            default: state_nxt = S_IDLE;
        endcase

        // A premature in_last truncates the decode; a missing one is only flagged.
        if (accept) begin
            if (in_last && !last_pos) begin
                len_set   = 1'b1;
                state_nxt = S_DONE;
            end else if (last_pos && !in_last) begin
                len_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done     <= 1'b0;
            err_len  <= 1'b0;
            err_hint <= 1'b0;
            c_tilde  <= '0;
            h        <= '0;
            z_poly   <= '0;
            z_idx    <= '0;
            byte_cnt <= '0;
            sec_cnt  <= '0;
            acc_bits <= '0;
            hi       <= '0;
            hidx     <= '0;
            first_i  <= '0;
            phase    <= P_CNT;
        end else begin
            done <= (state_nxt == S_DONE) && (state != S_DONE);
            if (start_ok) begin
                err_len  <= 1'b0;
                err_hint <= 1'b0;
                h        <= '0;
                z_poly   <= '0;
                z_idx    <= '0;
                byte_cnt <= '0;
                sec_cnt  <= '0;
                acc_bits <= '0;
                hi       <= '0;
                hidx     <= '0;
                first_i  <= '0;
                phase    <= P_CNT;
            end else begin
                if (len_set)  err_len  <= 1'b1;
                if (hint_set) err_hint <= 1'b1;
                if (accept) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    case (state)
                        S_CT: begin
                            c_tilde[{sec_cnt, 3'b000} +: 8] <= in_data;
                            sec_cnt <= (sec_cnt == SCW'(CT - 1)) ? '0 : sec_cnt + 1'b1;
                        end
                        S_Z:     acc_bits <= acc_bits + ABW'(DATA_W);
                        S_HBUF:  sec_cnt  <= sec_cnt + 1'b1;
                        default: ;
                    endcase
                end
                // Intake and emit are mutually exclusive in Z.
                if (z_fire) begin
                    acc_bits <= acc_bits - B_A;
                    z_idx    <= z_idx + 8'd1;
                    if (z_idx == 8'd255 && !z_last) z_poly <= z_poly + 1'b1;
                end
                if (state == S_HCHK) begin
                    phase <= phase_nxt;
                    if (hi_inc)   hi      <= hi + 1'b1;
                    if (hidx_inc) hidx    <= hidx + 1'b1;
                    if (first_ld) first_i <= hidx;
                    if (h_wr)     h[{hi, hent}] <= 1'b1;
                end
            end
        end
    end

    // Bits at and above acc_bits are don't-care, so a byte is written in place.
    always_ff @(posedge clk) begin
        if (accept && state == S_Z)        acc[acc_bits +: 8] <= in_data;
        else if (z_fire)                   acc <= acc >> B;
        if (accept && state == S_HBUF)     y[YAW'(sec_cnt)] <= in_data;
    end

endmodule

// File: tb/tb_sig_stream_decode.sv
module tb_sig_stream_decode;

    localparam int LAMBDA = 192;
    localparam int L      = 5;
    localparam int K      = 6;
    localparam int OMEGA  = 55;
    localparam int G1     = 19;
    localparam int CT     = LAMBDA / 4;
    localparam int B      = G1 + 1;
    localparam int ZB     = L * 32 * B;
    localparam int NZ     = L * 256;
    localparam int HOFF   = CT + ZB;
    localparam int TOTAL  = HOFF + OMEGA + K;
    localparam int GAMMA1 = 1 << G1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [8*CT-1:0]   c_tilde;
    logic [31:0]       z_coeff;
    logic [2:0]        z_poly;
    logic [7:0]        z_idx;
    logic              z_valid;
    logic              z_ready = 1'b1;
    logic [K*256-1:0]  h;
    logic              done;
    logic              sig_ok;
    logic              err_len;
    logic              err_hint;

    sig_stream_decode #(
        .LAMBDA(LAMBDA), .L(L), .K(K), .OMEGA(OMEGA), .GAMMA1_BITS(G1)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .c_tilde(c_tilde), .z_coeff(z_coeff), .z_poly(z_poly), .z_idx(z_idx),
        .z_valid(z_valid), .z_ready(z_ready), .h(h), .done(done), .sig_ok(sig_ok),
        .err_len(err_len), .err_hint(err_hint)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit rmode = 1'b0;
    logic [7:0] sig [0:TOTAL-1];
    int got_z[$];
    int got_p[$];
    int got_i[$];
    int ref_z[$];
    logic [8*CT-1:0] exp_ct;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (done) done_cnt++;

    // Coefficient sink: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        z_ready = rmode ? ($urandom_range(0, 99) < 30) : 1'b1;
        #1;
        if (z_valid && z_ready) begin
            got_z.push_back(int'($signed(z_coeff)));
            got_p.push_back(int'(z_poly));
            got_i.push_back(int'(z_idx));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: extract coefficient c bit by bit from the z byte region.
    function automatic int exp_z(input int c);
        int f = 0;
        for (int b = 0; b < B; b++) begin
            int n = c * B + b;
            f |= ((sig[CT + n / 8] >> (n % 8)) & 1) << b;
        end
        return GAMMA1 - f;
    endfunction

    function automatic int zmis();
        int m = 0;
        for (int c = 0; c < got_z.size(); c++)
            if (got_z[c] != exp_z(c) || got_p[c] != c / 256 || got_i[c] != c % 256) m++;
        return m;
    endfunction

    function automatic int qz(input int c);
        return (got_z.size() > c) ? got_z[c] : 32'h7fffffff;
    endfunction

    task automatic fill_base();
        for (int j = 0; j < TOTAL; j++) sig[j] = 8'h00;
        for (int j = 0; j < CT; j++)    sig[j] = 8'(j);
    endtask

    task automatic set_hint3();
        sig[HOFF + 0] = 8'd3;
        sig[HOFF + 1] = 8'd7;
        sig[HOFF + 2] = 8'd200;
        for (int i = 0; i < K; i++) sig[HOFF + OMEGA + i] = 8'd3;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send(input int n, input int last_at);
        int k = 0;
        int g = 0;
        int d0 = done_cnt;
        while (k < n && g < 30000) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = sig[k];
            in_last  = (k == last_at);
            #1;
            if (in_ready) k++;
            else if (done_cnt != d0) break;
            g++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (g >= 30000) check("send_bound", k, n);
    endtask

    task automatic run(input int last_at, input bit rm, output int lat);
        int d0;
        got_z.delete(); got_p.delete(); got_i.delete();
        rmode = rm;
        d0 = done_cnt;
        pulse_start();
        send(TOTAL, last_at);
        lat = 0;
        while (done_cnt == d0 && lat < 500) begin
            @(negedge clk); #1; lat++;
        end
        if (done_cnt == d0) check("done_timeout", done_cnt, d0 + 1);
        rmode = 1'b0;
    endtask

    initial begin
        int lat;
        int m;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        for (int j = 0; j < CT; j++) exp_ct[8*j +: 8] = 8'(j);

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_z_valid", z_valid, 0);
        check("rst_done", done, 0);
        check("rst_sig_ok", sig_ok, 0);
        check("rst_errs", {err_len, err_hint}, 0);
        check("rst_ct", c_tilde == '0, 1);
        check("rst_h", $countones(h), 0);
        check("rst_pos", {z_poly, z_idx}, 0);
        @(negedge clk); rst = 1'b1;

        // Nominal all-zero signature
        fill_base();
        run(TOTAL - 1, 1'b0, lat);
        check("A_ct", c_tilde == exp_ct, 1);
        check("A_ct5", c_tilde[47:40], 5);
        check("A_nz", got_z.size(), NZ);
        check("A_z0", qz(0), GAMMA1);
        check("A_zlast", qz(NZ - 1), GAMMA1);
        check("A_zmis", zmis(), 0);
        check("A_h", $countones(h), 0);
        check("A_sig_ok", sig_ok, 1);
        check("A_errs", {err_len, err_hint}, 0);
        check("A_in_ready", in_ready, 0);
        check("A_lat", lat <= 2 * OMEGA + K + 2, 1);

        // Extreme field value and a valid hint set
        fill_base();
        sig[CT] = 8'hFF; sig[CT + 1] = 8'hFF; sig[CT + 2] = 8'h0F;
        set_hint3();
        run(TOTAL - 1, 1'b0, lat);
        check("B_z0", qz(0), -524287);
        check("B_pos0", got_p.size() > 0 ? got_p[0] * 256 + got_i[0] : -1, 0);
        check("B_z1", qz(1), GAMMA1);
        check("B_zmis", zmis(), 0);
        check("B_h3", h[3], 1);
        check("B_h7", h[7], 1);
        check("B_h200", h[200], 1);
        check("B_hcnt", $countones(h), 3);
        check("B_sig_ok", sig_ok, 1);

        // Patterned z with full throughput, then with a 30% z_ready duty
        fill_base();
        for (int j = 0; j < ZB; j++) sig[CT + j] = 8'((j * 37 + 11) & 255);
        run(TOTAL - 1, 1'b0, lat);
        check("P1_nz", got_z.size(), NZ);
        check("P1_z0", qz(0), 184309);
        check("P1_zmis", zmis(), 0);
        ref_z = got_z;
        run(TOTAL - 1, 1'b1, lat);
        check("P2_nz", got_z.size(), NZ);
        m = 0;
        for (int c = 0; c < NZ; c++) if (qz(c) != ref_z[c]) m++;
        check("P2_seq", m, 0);
        check("P2_zmis", zmis(), 0);
        check("P2_sig_ok", sig_ok, 1);

        // Hint malformations
        fill_base(); set_hint3();
        sig[HOFF + 0] = 8'd7; sig[HOFF + 1] = 8'd3;
        run(TOTAL - 1, 1'b0, lat);
        check("H1_err_hint", err_hint, 1);
        check("H1_sig_ok", sig_ok, 0);
        check("H1_err_len", err_len, 0);

        fill_base();
        sig[HOFF + OMEGA] = 8'd56;
        run(TOTAL - 1, 1'b0, lat);
        check("H2_err_hint", err_hint, 1);
        check("H2_lat", lat <= 2, 1);
        check("H2_sig_ok", sig_ok, 0);

        fill_base(); set_hint3();
        sig[HOFF + 10] = 8'd5;
        run(TOTAL - 1, 1'b0, lat);
        check("H3_err_hint", err_hint, 1);
        check("H3_h3", h[3], 1);
        check("H3_sig_ok", sig_ok, 0);

        // Length errors
        fill_base();
        run(100, 1'b0, lat);
        check("L1_err_len", err_len, 1);
        check("L1_sig_ok", sig_ok, 0);
        repeat (2) @(negedge clk);
        #1;
        check("L1_in_ready", in_ready, 0);

        fill_base(); set_hint3();
        run(-1, 1'b0, lat);
        check("L2_err_len", err_len, 1);
        check("L2_err_hint", err_hint, 0);
        check("L2_sig_ok", sig_ok, 0);
        check("L2_hcnt", $countones(h), 3);
        check("L2_h200", h[200], 1);

        // Reset in the middle of Z, then a clean decode
        fill_base();
        sig[CT] = 8'hFF; sig[CT + 1] = 8'hFF; sig[CT + 2] = 8'h0F;
        set_hint3();
        pulse_start();
        send(600, -1);
        rst = 1'b0;
        #1;
        check("R_in_ready", in_ready, 0);
        check("R_z_valid", z_valid, 0);
        check("R_pos", {z_poly, z_idx}, 0);
        check("R_ct", c_tilde == '0, 1);
        check("R_flags", {done, sig_ok, err_len, err_hint}, 0);
        @(negedge clk); rst = 1'b1;
        run(TOTAL - 1, 1'b0, lat);
        check("R2_nz", got_z.size(), NZ);
        check("R2_z0", qz(0), -524287);
        check("R2_zmis", zmis(), 0);
        check("R2_hcnt", $countones(h), 3);
        check("R2_sig_ok", sig_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
